// File: rtl/dmem_port_arbiter_if.sv
// Bundle of MEM-stage, debug-loader and BRAM signals shared by the data-port arbiter.
// The arbiter uses the slave view; the pipeline, loader and RAM side use the master view.
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 10
);
  logic              dbg;
  logic              cpu_rea;
  logic              cpu_wea;
  logic [3:0]        cpu_en;
  logic [31:0]       cpu_addr;
  logic [31:0]       cpu_din;
  logic [31:0]       cpu_dout;
  logic              mem_hold;

  logic              ld_req;
  logic              ld_we;
  logic [3:0]        ld_be;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_din;
  logic              ld_gnt;
  logic              ld_rvalid;
  logic [31:0]       ld_dout;

  logic              ram_en;
  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_din;
  logic [31:0]       ram_dout;

  modport master (
    output dbg, cpu_rea, cpu_wea, cpu_en, cpu_addr, cpu_din,
    output ld_req, ld_we, ld_be, ld_addr, ld_din,
    output ram_dout,
    input  cpu_dout, mem_hold, ld_gnt, ld_rvalid, ld_dout,
    input  ram_en, ram_we, ram_addr, ram_din
  );

  modport slave (
    input  dbg, cpu_rea, cpu_wea, cpu_en, cpu_addr, cpu_din,
    input  ld_req, ld_we, ld_be, ld_addr, ld_din,
    input  ram_dout,
    output cpu_dout, mem_hold, ld_gnt, ld_rvalid, ld_dout,
    output ram_en, ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares the single data-BRAM port between the MEM stage and the UART debug loader.
// CPU has priority; a starvation counter forces one loader slot and freezes the pipeline for it.
module dmem_port_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 Rst,
  dmem_port_arbiter_if.slave   bus
);

  localparam int                CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic {
    OWNER_CPU   = 1'b0,
    OWNER_OTHER = 1'b1
  } owner_e;

  logic w_cpuAct;
  logic w_oor;
  logic w_force;
  logic w_ldWin;
  logic w_ldGnt;
  logic w_cpuSlot;
  logic w_oorAccess;

  owner_e           r_owner;
  logic             r_oor;
  logic [31:0]      r_dout;
  logic [CNT_W-1:0] r_starve;
  logic             r_ldRvalid;

  assign w_cpuAct    = (bus.cpu_rea | bus.cpu_wea) & ~bus.dbg;
  assign w_oor       = |bus.cpu_addr[31:ADDR_W+2];
  assign w_oorAccess = w_cpuAct & w_oor;
  assign w_force     = bus.ld_req & (r_starve == LIMIT);
  assign w_ldWin     = bus.ld_req & (~w_cpuAct | w_oor | w_force);

  // Reset gates every slot so nothing reaches the RAM, including an aborted forced slot.
  assign w_ldGnt   = w_ldWin & ~Rst;
  assign w_cpuSlot = w_cpuAct & ~w_oor & ~w_ldWin & ~Rst;

  assign bus.ld_gnt   = w_ldGnt;
  assign bus.mem_hold = w_force & w_cpuAct & ~w_oor & ~Rst;

  always_comb begin
    bus.ram_en   = 1'b0;
    bus.ram_we   = 4'b0000;
    bus.ram_addr = '0;
    bus.ram_din  = '0;
    if (w_ldGnt) begin
      bus.ram_en   = 1'b1;
      bus.ram_we   = bus.ld_we ? bus.ld_be : 4'b0000;
      bus.ram_addr = bus.ld_addr;
      bus.ram_din  = bus.ld_din;
    end else if (w_cpuSlot) begin
      bus.ram_en   = 1'b1;
      bus.ram_we   = bus.cpu_wea ? bus.cpu_en : 4'b0000;
      bus.ram_addr = bus.cpu_addr[ADDR_W+1:2];
      bus.ram_din  = bus.cpu_din;
    end
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      r_owner    <= OWNER_CPU;
      r_oor      <= 1'b0;
      r_dout     <= '0;
      r_starve   <= '0;
      r_ldRvalid <= 1'b0;
    end else begin
      r_owner    <= w_cpuSlot ? OWNER_CPU : OWNER_OTHER;
      r_ldRvalid <= w_ldGnt & ~bus.ld_we;

      // Capture CPU read data while it is on ram_dout so later loader slots cannot disturb it.
      if (r_owner == OWNER_CPU) begin
        r_dout <= bus.ram_dout;
      end

      if (w_oorAccess) begin
        r_oor <= 1'b1;
      end else if (w_cpuSlot) begin
        r_oor <= 1'b0;
      end

      if (w_ldGnt | ~bus.ld_req) begin
        r_starve <= '0;
      end else if (r_starve != LIMIT) begin
        r_starve <= r_starve + CNT_W'(1);
      end
    end
  end

  always_comb begin
    bus.cpu_dout = '0;
    if (!r_oor) begin
      bus.cpu_dout = (r_owner == OWNER_CPU) ? bus.ram_dout : r_dout;
    end
  end

  assign bus.ld_rvalid = r_ldRvalid;
  assign bus.ld_dout   = r_ldRvalid ? bus.ram_dout : 32'h0;

endmodule
